// File: rtl/demux_arb.sv
// rtl/demux_arb.sv - round-robin arbiter driving an 8-way demux select
// Optional forced release: define DEMUX_ARB_TIMEOUT_EN to cap a grant at MAX_HOLD cycles.
module demux_arb #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req,
  output logic [2:0] sel,
  output logic [7:0] grant,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t     state;
  logic [2:0] ptr;
  logic [2:0] win;

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("demux_arb: MAX_HOLD must be in 2..255");
  end

  // First requester at or above ptr, wrapping 7 -> 0.
  function automatic logic [2:0] pick(input logic [7:0] r, input logic [2:0] p);
    logic [2:0] idx;
    logic       found;
    pick  = p;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idx = p + 3'(i);
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  endfunction

  assign win = pick(req, ptr);

`ifdef DEMUX_ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] hold_cnt;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      sel     <= 3'd0;
      grant   <= 8'd0;
      busy    <= 1'b0;
      timeout <= 1'b0;
      ptr     <= 3'd0;
`ifdef DEMUX_ARB_TIMEOUT_EN
      hold_cnt <= 8'd0;
`endif
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE, GAP: begin
          if (req != 8'd0) begin
            state <= GRANT;
            sel   <= win;
            grant <= 8'd1 << win;
            busy  <= 1'b1;
            ptr   <= win + 3'd1;
`ifdef DEMUX_ARB_TIMEOUT_EN
            hold_cnt <= 8'd0;
`endif
          end else begin
            state <= IDLE;
            grant <= 8'd0;
            busy  <= 1'b0;
          end
        end
        GRANT: begin
          if (!req[sel]) begin
            state <= GAP;
            grant <= 8'd0;
            busy  <= 1'b0;
          end
`ifdef DEMUX_ARB_TIMEOUT_EN
          // hold_cnt counts completed grant cycles; the MAX_HOLD-th one is the last.
          else if (hold_cnt == HOLD_LAST) begin
            state   <= GAP;
            grant   <= 8'd0;
            busy    <= 1'b0;
            timeout <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
`endif
        end
        default: begin
          state <= IDLE;
          grant <= 8'd0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/demux_arb.md
DEMUX_ARB -- requirements
Module: demux_arb

Interface
REQ-001 Parameter: MAX_HOLD, default 16, maximum consecutive GRANT cycles per grant when the timeout feature is compiled in; legal range 2..255.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req  input  8  request vector; bit n = requester n wants demux output n.
REQ-005 sel  output  3  binary index of current or last granted requester; drives the demux select.
REQ-006 grant  output  8  one-hot grant, equal to 1<<sel in GRANT state; all-zero otherwise.
REQ-007 busy  output  1  high only while in GRANT state.
REQ-008 timeout  output  1  one-cycle pulse on forced release; constant 0 when the feature is compiled out.

Function
REQ-009 FSM states: IDLE, GRANT, GAP; all outputs registered; no combinational path from req to any output.
REQ-010 Arbitration is evaluated in IDLE and GAP: if req != 0, select the first set bit scanning upward from ptr, wrapping 7->0.
REQ-011 Arbitration win: next edge enters GRANT, loads sel with the winner, sets grant=1<<winner, sets busy=1, and sets ptr=(winner+1) mod 8 (7 wraps to 0).
REQ-012 Latency: req asserted at edge k into idle arbiter -> grant visible after edge k+1.
REQ-013 In GRANT, req[sel] sampled low -> next state GAP; other req bits are ignored while in GRANT.
REQ-014 GAP lasts exactly one cycle with grant=0, busy=0; sel holds its value; then GRANT (if req!=0, per REQ-010) or IDLE.
REQ-015 IDLE with req==0 -> remain IDLE; grant=0, busy=0, sel holds.
REQ-016 Fairness: a continuously requesting line waits for at most 7 other grants before being served.
REQ-017 grant never has more than one bit set; grant is never nonzero outside GRANT.
REQ-018 A requester that drops req in the same cycle it is granted still receives exactly one GRANT cycle, followed by GAP.

Reset
REQ-019 reset high at an edge -> state=IDLE, sel=0, grant=0, busy=0, timeout=0, ptr=0, hold counter=0; it overrides every other condition, including mid-grant.
REQ-020 First arbitration after reset release starts scanning from index 0.

Configuration
REQ-021 Macro DEMUX_ARB_TIMEOUT_EN defined: an 8-bit hold counter clears on GRANT entry and increments each GRANT cycle.
REQ-022 When the counter reaches MAX_HOLD with req[sel] still high, the arbiter forces GRANT->GAP and timeout pulses high for the GAP cycle.
REQ-023 A timed-out requester is rotated normally: ptr has already advanced past it, so other pending requesters are served first.
REQ-024 Macro DEMUX_ARB_TIMEOUT_EN undefined: no hold counter, timeout tied 0, and a grant persists until req[sel] drops.

Verification
REQ-025 Reset, then req=8'b0000_0100 held 3 cycles then 0 -> sel=2, grant=8'b0000_0100 for 3 cycles, 1 GAP cycle, then IDLE; busy tracks grant.
REQ-026 req=8'hFF, each requester drops after 1 grant cycle -> grant order 0,1,2,...,7; each separated by 1 GAP cycle; ptr wraps back to 0.
REQ-027 ptr=6 (after grant to 5), req=8'b1000_0001 -> grant to 7 first, then 0.
REQ-028 TIMEOUT_EN, MAX_HOLD=4, req=8'b0000_1001 held high -> grant 0 for 4 cycles, timeout pulse, GAP, grant 3 for 4 cycles, timeout, GAP, grant 0 again.
REQ-029 Assert reset during cycle 2 of a grant to requester 5 -> next edge grant=0, sel=0, busy=0; with req still 8'b0010_0000, grant returns 2 edges after reset release.
REQ-030 Without TIMEOUT_EN, req=8'b0000_0011 held 40 cycles -> grant stays 8'b0000_0001 for all 40 cycles; timeout stays 0 throughout.
